// File: rtl/serial_word_receiver.sv
// Serial word receiver: start bit, S data bits LSB first, even parity, stop bit.
// Good frames are held in a one-word output buffer with a valid/ready handshake.
module serial_word_receiver #(
    parameter int S = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         serin,
    input  logic         serval,
    input  logic         ready,
    output logic [S-1:0] data,
    output logic         valid,
    output logic         perr,
    output logic         ferr,
    output logic         ovr,
    output logic [7:0]   errcnt
);
    localparam int CW = $clog2(S);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    state_t        state_r, state_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic [S-1:0]  shift_r, shift_s;
    logic          par_r, par_s;
    logic [S-1:0]  data_r, data_s;
    logic          valid_r, valid_s;
    logic          perr_r, perr_s;
    logic          ferr_r, ferr_s;
    logic          ovr_r, ovr_s;
    logic [7:0]    errcnt_r, errcnt_s;
    logic          err_s;

    // Returns 1 when the data bits plus parity bit have odd weight.
    function automatic logic parity_bad(input logic [S-1:0] d, input logic p);
        return (^d) ^ p;
    endfunction

    // Next-state, datapath and handshake logic.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        shift_s  = shift_r;
        par_s    = par_r;
        data_s   = data_r;
        perr_s   = 1'b0;
        ferr_s   = 1'b0;
        ovr_s    = 1'b0;
        if (valid_r && ready) begin
            valid_s = 1'b0;
        end else begin
            valid_s = valid_r;
        end

        if (serval) begin
            case (state_r)
                IDLE: begin
                    if (!serin) begin
                        state_s = DATA;
                        cnt_s   = {CW{1'b0}};
                    end else begin
                        state_s = IDLE;
                    end
                end
                DATA: begin
                    shift_s = {serin, shift_r[S-1:1]};
                    if (cnt_r == CW'(S - 1)) begin
                        state_s = PARITY;
                        cnt_s   = {CW{1'b0}};
                    end else begin
                        cnt_s   = cnt_r + CW'(1);
                    end
                end
                PARITY: begin
                    par_s   = serin;
                    state_s = STOP;
                end
                STOP: begin
                    state_s = IDLE;
                    // Framing errors take precedence so a frame yields at most one pulse.
                    if (!serin) begin
                        ferr_s = 1'b1;
                    end else if (parity_bad(shift_r, par_r)) begin
                        perr_s = 1'b1;
                    end else if (!valid_r || ready) begin
                        data_s  = shift_r;
                        valid_s = 1'b1;
                    end else begin
                        ovr_s = 1'b1;
                    end
                end
                default: begin
                    state_s = IDLE;
                    cnt_s   = {CW{1'b0}};
                end
            endcase
        end else begin
            state_s = state_r;
        end

        err_s = perr_s | ferr_s | ovr_s;
        if (err_s && (errcnt_r != 8'd255)) begin
            errcnt_s = errcnt_r + 8'd1;
        end else begin
            errcnt_s = errcnt_r;
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= IDLE;
            cnt_r    <= {CW{1'b0}};
            shift_r  <= {S{1'b0}};
            par_r    <= 1'b0;
            data_r   <= {S{1'b0}};
            valid_r  <= 1'b0;
            perr_r   <= 1'b0;
            ferr_r   <= 1'b0;
            ovr_r    <= 1'b0;
            errcnt_r <= 8'd0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            shift_r  <= shift_s;
            par_r    <= par_s;
            data_r   <= data_s;
            valid_r  <= valid_s;
            perr_r   <= perr_s;
            ferr_r   <= ferr_s;
            ovr_r    <= ovr_s;
            errcnt_r <= errcnt_s;
        end
    end

    assign data   = data_r;
    assign valid  = valid_r;
    assign perr   = perr_r;
    assign ferr   = ferr_r;
    assign ovr    = ovr_r;
    assign errcnt = errcnt_r;

endmodule

// File: tb/tb_serial_word_receiver.sv
// Self-checking bench for serial_word_receiver: frame-level reference model
// compared every cycle, plus directed literal checks.
module tb_serial_word_receiver;
    localparam int S = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         serin = 1'b1;
    logic         serval = 1'b0;
    logic         ready = 1'b1;
    logic [S-1:0] data;
    logic         valid, perr, ferr, ovr;
    logic [7:0]   errcnt;

    int n_checks = 0;
    int n_pass   = 0;

    serial_word_receiver #(.S(S)) dut (
        .clk(clk), .rst(rst), .serin(serin), .serval(serval), .ready(ready),
        .data(data), .valid(valid), .perr(perr), .ferr(ferr), .ovr(ovr),
        .errcnt(errcnt)
    );

    always #5 clk = ~clk;

    // Reference model: collects the bits of a frame after a start bit, judges it when complete.
    logic [S-1:0] m_data = '0;
    logic         m_valid = 1'b0, m_perr = 1'b0, m_ferr = 1'b0, m_ovr = 1'b0;
    int           m_errcnt = 0;
    bit           in_frame = 1'b0;
    bit           bits[$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_data = '0; m_valid = 1'b0; m_perr = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
            m_errcnt = 0; in_frame = 1'b0; bits.delete();
        end else begin
            bit load, consumed, e_p, e_f, e_o;
            logic [S-1:0] word;
            int ones;
            load = 0; e_p = 0; e_f = 0; e_o = 0; word = '0;
            consumed = m_valid && ready;
            if (serval) begin
                if (!in_frame) begin
                    if (serin == 1'b0) begin
                        in_frame = 1'b1;
                        bits.delete();
                    end
                end else begin
                    bits.push_back(serin);
                    if (bits.size() == S + 2) begin
                        in_frame = 1'b0;
                        ones = 0;
                        for (int i = 0; i < S; i++) begin
                            word[i] = bits[i];
                            ones += int'(bits[i]);
                        end
                        ones += int'(bits[S]);
                        if (bits[S+1] == 1'b0) e_f = 1;
                        else if (ones % 2 != 0) e_p = 1;
                        else if (!m_valid || ready) load = 1;
                        else e_o = 1;
                    end
                end
            end
            if (load) begin
                m_valid = 1'b1;
                m_data  = word;
            end else if (consumed) begin
                m_valid = 1'b0;
            end
            m_perr = e_p; m_ferr = e_f; m_ovr = e_o;
            if (e_p || e_f || e_o) m_errcnt = (m_errcnt >= 255) ? 255 : m_errcnt + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    // Per-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        chk("model_data",   {24'd0, data},        {24'd0, m_data});
        chk("model_valid",  {31'd0, valid},       {31'd0, m_valid});
        chk("model_perr",   {31'd0, perr},        {31'd0, m_perr});
        chk("model_ferr",   {31'd0, ferr},        {31'd0, m_ferr});
        chk("model_ovr",    {31'd0, ovr},         {31'd0, m_ovr});
        chk("model_errcnt", {24'd0, errcnt},      m_errcnt);
    end

    // Called at a negedge; returns at the negedge after the bit is sampled.
    task automatic send_bit(input logic b, input int gap);
        for (int g = 0; g < gap; g++) @(negedge clk);
        serval = 1'b1;
        serin  = b;
        @(negedge clk);
        serval = 1'b0;
        serin  = 1'b1;
    endtask

    task automatic send_frame(input logic [S-1:0] w, input logic par_flip, input logic stop,
                              input int max_gap, input bit rdy_at_stop);
        logic p;
        p = (^w) ^ par_flip;
        send_bit(1'b0, $urandom_range(max_gap));
        for (int i = 0; i < S; i++) send_bit(w[i], $urandom_range(max_gap));
        send_bit(p, $urandom_range(max_gap));
        if (rdy_at_stop) ready = 1'b1;
        send_bit(stop, $urandom_range(max_gap));
    endtask

    initial begin
        logic [7:0] seq_bits [0:10];
        seq_bits = '{8'd0, 8'd1, 8'd0, 8'd1, 8'd0, 8'd0, 8'd1, 8'd0, 8'd1, 8'd0, 8'd1};
        @(negedge clk);
        chk("reset_valid", {31'd0, valid}, 32'd0);
        chk("reset_errcnt", {24'd0, errcnt}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Literal bit stream for 0xA5 with ready=1.
        for (int i = 0; i < 11; i++) send_bit(seq_bits[i][0], 0);
        chk("a5_data", {24'd0, data}, 32'h0000_00A5);
        chk("a5_valid", {31'd0, valid}, 32'd1);
        chk("a5_noerr", {29'd0, perr, ferr, ovr}, 32'd0);
        @(negedge clk);
        chk("a5_valid_clears", {31'd0, valid}, 32'd0);

        // Same word with gaps between strobes.
        send_frame(8'hA5, 1'b0, 1'b1, 5, 1'b0);
        chk("a5gap_data", {24'd0, data}, 32'h0000_00A5);
        chk("a5gap_valid", {31'd0, valid}, 32'd1);

        send_frame(8'hA5, 1'b1, 1'b1, 0, 1'b0);
        chk("perr_pulse", {31'd0, perr}, 32'd1);
        chk("perr_valid", {31'd0, valid}, 32'd0);
        chk("perr_errcnt", {24'd0, errcnt}, 32'd1);
        @(negedge clk);
        chk("perr_one_cycle", {31'd0, perr}, 32'd0);

        send_frame(8'h3C, 1'b0, 1'b0, 2, 1'b0);
        chk("ferr_only", {29'd0, perr, ferr, ovr}, 32'd2);
        chk("ferr_valid", {31'd0, valid}, 32'd0);
        chk("ferr_errcnt", {24'd0, errcnt}, 32'd2);

        ready = 1'b0;
        send_frame(8'h11, 1'b0, 1'b1, 1, 1'b0);
        chk("hold_data", {24'd0, data}, 32'h11);
        chk("hold_valid", {31'd0, valid}, 32'd1);
        send_frame(8'h22, 1'b0, 1'b1, 0, 1'b0);
        chk("ovr_pulse", {31'd0, ovr}, 32'd1);
        chk("ovr_data_kept", {24'd0, data}, 32'h11);
        chk("ovr_valid_kept", {31'd0, valid}, 32'd1);
        chk("ovr_errcnt", {24'd0, errcnt}, 32'd3);
        send_frame(8'h22, 1'b0, 1'b1, 0, 1'b1);
        chk("replace_data", {24'd0, data}, 32'h22);
        chk("replace_valid", {31'd0, valid}, 32'd1);
        chk("replace_no_ovr", {31'd0, ovr}, 32'd0);
        @(negedge clk);
        chk("replace_valid_clears", {31'd0, valid}, 32'd0);

        // Asynchronous reset after start + 4 data bits, with a word held.
        ready = 1'b0;
        send_frame(8'h77, 1'b0, 1'b1, 0, 1'b0);
        send_bit(1'b0, 0);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 0);
        #2 rst = 1'b1;
        #1;
        chk("arst_outputs", {data, valid, perr, ferr, ovr, errcnt}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        ready = 1'b1;
        @(negedge clk);
        send_frame(8'h5A, 1'b0, 1'b1, 3, 1'b0);
        chk("post_rst_data", {24'd0, data}, 32'h5A);
        chk("post_rst_valid", {31'd0, valid}, 32'd1);
        chk("post_rst_errcnt", {24'd0, errcnt}, 32'd0);

        // Saturation: 255 errors reach the limit, the 256th must not wrap.
        for (int k = 0; k < 255; k++) send_frame(8'(k), 1'b1, 1'b1, (k % 3 == 0) ? 5 : 0, 1'b0);
        chk("sat_255", {24'd0, errcnt}, 32'd255);
        send_frame(8'h00, 1'b1, 1'b1, 4, 1'b0);
        chk("sat_256_perr", {31'd0, perr}, 32'd1);
        chk("sat_256", {24'd0, errcnt}, 32'd255);
        send_frame(8'hFF, 1'b0, 1'b0, 2, 1'b0);
        chk("sat_stays", {24'd0, errcnt}, 32'd255);
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
